// File: rtl/uxa_ps2_tx_if.sv
// I/O bus port of the UXA PS/2 transmitter: command byte write, status word read,
// single-cycle acknowledge per strobe.
interface uxa_ps2_tx_if;
  logic        io_stb_i;
  logic        io_we_i;
  logic [7:0]  io_dat_i;
  logic        io_ack_o;
  logic [15:0] io_dat_o;

  modport master (output io_stb_i, io_we_i, io_dat_i, input io_ack_o, io_dat_o);
  modport slave  (input io_stb_i, io_we_i, io_dat_i, output io_ack_o, io_dat_o);
endinterface

// File: rtl/uxa_ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift a byte on device clocks,
// then check the device ACK. Optional watchdog is built when UXA_PS2_TX_TIMEOUT_EN is defined.
module uxa_ps2_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        sys_clk_i,
  input  logic        sys_reset_n_i,
  input  logic        ps2_c_i,
  input  logic        ps2_d_i,
  output logic        ps2_c_oe_o,
  output logic        ps2_d_oe_o,
  uxa_ps2_tx_if.slave io,
  output logic        busy_o,
  output logic        done_o
);
  localparam int unsigned CNT_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } state_t;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [3:0]       idx_q, idx_n;
  logic [7:0]       data_q, data_n;
  logic             err_q, err_n;
  logic             acks_q, acks_n;
  logic             c_oe_q, c_oe_n;
  logic             d_oe_q, d_oe_n;
  logic             ack_q;
  logic             done_c;
  logic             c_s1, c_s2, c_prev, d_s1, d_s2;
  logic             fall;
  logic             wr;
  logic             par_bit;

  // Lines idle high, so the synchronizers reset high to avoid a phantom falling edge.
  always_ff @(posedge sys_clk_i or negedge sys_reset_n_i) begin
    if (!sys_reset_n_i) begin
      c_s1   <= 1'b1;
      c_s2   <= 1'b1;
      c_prev <= 1'b1;
      d_s1   <= 1'b1;
      d_s2   <= 1'b1;
    end else begin
      c_s1   <= ps2_c_i;
      c_s2   <= c_s1;
      c_prev <= c_s2;
      d_s1   <= ps2_d_i;
      d_s2   <= d_s1;
    end
  end

  assign fall    = c_prev & ~c_s2;
  assign wr      = io.io_stb_i & io.io_we_i;
  assign par_bit = ~^data_q;

`ifdef UXA_PS2_TX_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q;
  logic            wd_hit;

  assign wd_hit = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  // Restarted on entry to SHIFT and on every device clock; saturates at the limit.
  always_ff @(posedge sys_clk_i or negedge sys_reset_n_i) begin
    if (!sys_reset_n_i) begin
      wd_q <= '0;
    end else if ((state_q == ST_RTS) || fall) begin
      wd_q <= '0;
    end else if (!wd_hit) begin
      wd_q <= wd_q + 1'b1;
    end
  end
`else
  // The timeout length only matters with the watchdog built in.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge sys_clk_i or negedge sys_reset_n_i) begin
    if (!sys_reset_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      acks_q  <= 1'b0;
      c_oe_q  <= 1'b0;
      d_oe_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      data_q  <= data_n;
      err_q   <= err_n;
      acks_q  <= acks_n;
      c_oe_q  <= c_oe_n;
      d_oe_q  <= d_oe_n;
      ack_q   <= io.io_stb_i & ~ack_q;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    data_n  = data_q;
    err_n   = err_q;
    acks_n  = acks_q;
    c_oe_n  = c_oe_q;
    d_oe_n  = d_oe_q;
    done_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        c_oe_n = 1'b0;
        d_oe_n = 1'b0;
        if (wr) begin
          data_n  = io.io_dat_i;
          err_n   = 1'b0;
          acks_n  = 1'b0;
          cnt_n   = CNT_W'(INHIBIT_CYCLES - 1);
          c_oe_n  = 1'b1;
          state_n = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        c_oe_n = 1'b1;
        if (cnt_q == '0) begin
          d_oe_n  = 1'b1;
          state_n = ST_RTS;
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      ST_RTS: begin
        // Releasing the clock with data held low presents the start bit.
        c_oe_n  = 1'b0;
        d_oe_n  = 1'b1;
        idx_n   = '0;
        state_n = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (fall) begin
          if (idx_q < 4'd8) begin
            d_oe_n = ~data_q[idx_q[2:0]];
          end else if (idx_q == 4'd8) begin
            d_oe_n = ~par_bit;
          end else begin
            d_oe_n = 1'b0;
          end
          idx_n = idx_q + 1'b1;
          if (idx_q == 4'd9) begin
            state_n = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        d_oe_n = 1'b0;
        if (fall) begin
          acks_n  = ~d_s2;
          err_n   = d_s2;
          state_n = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (c_s2 && d_s2) begin
          done_c  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: begin
        c_oe_n  = 1'b0;
        d_oe_n  = 1'b0;
        state_n = ST_IDLE;
      end
    endcase

`ifdef UXA_PS2_TX_TIMEOUT_EN
    if (wd_hit && (state_q inside {ST_SHIFT, ST_ACK, ST_WAIT_IDLE})) begin
      c_oe_n  = 1'b0;
      d_oe_n  = 1'b0;
      err_n   = 1'b1;
      done_c  = 1'b1;
      state_n = ST_IDLE;
    end
`endif
  end

  // busy drops in the done cycle, while the state still blocks a new write.
  assign done_o      = done_c;
  assign busy_o      = (state_q != ST_IDLE) & ~done_c;
  assign ps2_c_oe_o  = c_oe_q;
  assign ps2_d_oe_o  = d_oe_q;
  assign io.io_ack_o = ack_q;
  assign io.io_dat_o = {busy_o, err_q, acks_q, 5'b0_0000, data_q};
endmodule
